banked_sram: RTL and testbench

//  Multi-bank, byte-writable block-RAM store for the DRAM emulator. It succeeds the single-port

---
 rtl/banked_sram_pkg.sv | 18 +
 rtl/sram_bank.sv | 30 +++
 rtl/banked_sram.sv | 131 +++++++++++++
 tb/tb_banked_sram.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/banked_sram_pkg.sv
// Shared types and defaults for the banked block-RAM store.
package banked_sram_pkg;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_READY,
    ST_DRAIN
  } state_t;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 2048;
  localparam int unsigned DEF_BANKS = 8;

  function automatic int unsigned byte_lanes(input int unsigned width);
    return width / 8;
  endfunction

endpackage

// File: rtl/sram_bank.sv
// One single-port bank: per-byte write, registered read, block-RAM inferable.
module sram_bank #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2048
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [WIDTH/8-1:0]       be,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // rdata only changes on reads, so clear writes never disturb a pending response
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int unsigned i = 0; i < WIDTH / 8; i++) begin
          if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/banked_sram.sv
// Multi-bank byte-writable store with hardware clear and pipelined read responses.
module banked_sram
  import banked_sram_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int unsigned BANKS   = DEF_BANKS,
  parameter int unsigned OUT_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_req,
  output logic                     init_done,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [$clog2(BANKS)-1:0] req_bank,
  input  logic [$clog2(DEPTH)-1:0] req_addr,
  input  logic [WIDTH/8-1:0]       req_be,
  input  logic [WIDTH-1:0]         req_wdata,
  output logic                     rsp_valid,
  output logic [$clog2(BANKS)-1:0] rsp_bank,
  output logic [WIDTH-1:0]         rsp_data
);

  localparam int unsigned BW  = $clog2(BANKS);
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned BEW = byte_lanes(WIDTH);

  state_t          state, state_nxt;
  logic [AW-1:0]   clr_cnt;
  logic            in_init, last_row, accept, rd_accept;
  logic [BANKS-1:0] bank_en;
  logic            bank_we;
  logic [BEW-1:0]  bank_be;
  logic [AW-1:0]   bank_addr;
  logic [WIDTH-1:0] bank_wdata;
  logic [WIDTH-1:0] rdata [BANKS];
  logic            v1;
  logic [BW-1:0]   b1;
  logic [WIDTH-1:0] sel_data;

  assign in_init   = (state == ST_INIT);
  assign last_row  = (clr_cnt == AW'(DEPTH - 1));
  assign accept    = req_valid && req_ready;
  assign rd_accept = accept && !req_we;

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    case (state)
      ST_INIT:  if (last_row) state_nxt = ST_READY;
      ST_READY: begin
        req_ready = 1'b1;
        if (clr_req) state_nxt = (OUT_REG != 0) ? ST_DRAIN : ST_INIT;
      end
      ST_DRAIN: state_nxt = ST_INIT;
      default:  state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      clr_cnt   <= '0;
      init_done <= 1'b0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= in_init ? clr_cnt + 1'b1 : '0;
      if (in_init && last_row)             init_done <= 1'b1;
      else if (state == ST_READY && clr_req) init_done <= 1'b0;
    end
  end

  assign bank_we    = in_init || req_we;
  assign bank_be    = in_init ? '1 : req_be;
  assign bank_addr  = in_init ? clr_cnt : req_addr;
  assign bank_wdata = in_init ? '0 : req_wdata;

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    assign bank_en[b] = in_init || (accept && req_bank == BW'(b));
    sram_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_bank (
      .clk   (clk),
      .en    (bank_en[b]),
      .we    (bank_we),
      .be    (bank_be),
      .addr  (bank_addr),
      .wdata (bank_wdata),
      .rdata (rdata[b])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      b1 <= '0;
    end else begin
      v1 <= rd_accept;
      if (rd_accept) b1 <= req_bank;
    end
  end

  assign sel_data = rdata[b1];

  if (OUT_REG != 0) begin : g_out_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rsp_valid <= 1'b0;
        rsp_bank  <= '0;
        rsp_data  <= '0;
      end else begin
        rsp_valid <= v1;
        if (v1) begin
          rsp_bank <= b1;
          rsp_data <= sel_data;
        end
      end
    end
  end else begin : g_out_comb
    // bank rdata is not reset, so a held copy provides the reset value and hold behaviour
    logic [WIDTH-1:0] held;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  held <= '0;
      else if (v1) held <= sel_data;
    end
    assign rsp_valid = v1;
    assign rsp_bank  = b1;
    assign rsp_data  = v1 ? sel_data : held;
  end

endmodule

// File: tb/tb_banked_sram.sv
// Randomized bench for banked_sram against an array/queue reference model.
module tb_banked_sram;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned DEPTH   = 32;
  localparam int unsigned BANKS   = 8;
  localparam int unsigned OUT_REG = 1;
  localparam int unsigned LAT     = 1 + OUT_REG;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr_req = 1'b0;
  logic        init_done;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_bank = '0;
  logic [4:0]  req_addr = '0;
  logic [3:0]  req_be = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [2:0]  rsp_bank;
  logic [31:0] rsp_data;

  banked_sram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BANKS(BANKS), .OUT_REG(OUT_REG)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_req   (clr_req),
    .init_done (init_done),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_bank  (req_bank),
    .req_addr  (req_addr),
    .req_be    (req_be),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_bank  (rsp_bank),
    .rsp_data  (rsp_data)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int unsigned due;
    logic [2:0]  bank;
    logic [31:0] data;
  } rsp_t;

  logic [31:0] mem [BANKS][DEPTH];
  rsp_t        q[$];
  int unsigned busy     = DEPTH;
  logic        init_exp = 1'b0;
  int unsigned cyc      = 0;
  logic [31:0] last_data = '0;

  task automatic zero_mem();
    for (int b = 0; b < BANKS; b++)
      for (int a = 0; a < DEPTH; a++) mem[b][a] = '0;
  endtask

  // Model: busy counts remaining not-ready cycles; memory is a plain 2-D array.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     = DEPTH;
      init_exp = 1'b0;
      q.delete();
      zero_mem();
    end else begin
      cyc++;
      if (busy != 0) begin
        if (busy == 1) init_exp = 1'b1;
        busy--;
      end else begin
        if (req_valid) begin
          if (req_we) begin
            for (int i = 0; i < 4; i++)
              if (req_be[i]) mem[req_bank][req_addr][i*8 +: 8] = req_wdata[i*8 +: 8];
          end else begin
            q.push_back('{due: cyc + LAT - 1, bank: req_bank, data: mem[req_bank][req_addr]});
          end
        end
        if (clr_req) begin
          busy     = OUT_REG + DEPTH;
          init_exp = 1'b0;
          zero_mem();
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) last_data = '0;
    check("req_ready", {31'b0, req_ready}, {31'b0, (busy == 0)});
    check("init_done", {31'b0, init_done}, {31'b0, init_exp});
    if (q.size() != 0 && q[0].due == cyc && rst_n) begin
      check("rsp_valid", {31'b0, rsp_valid}, 32'd1);
      check("rsp_bank", {29'b0, rsp_bank}, {29'b0, q[0].bank});
      check("rsp_data", rsp_data, q[0].data);
      last_data = q[0].data;
      void'(q.pop_front());
    end else begin
      check("rsp_idle", {31'b0, rsp_valid}, 32'd0);
      check("rsp_hold", rsp_data, last_data);
    end
  end

  task automatic drive(input logic v, input logic we, input logic [2:0] b, input logic [4:0] a,
                       input logic [3:0] be, input logic [31:0] d, input logic clr);
    @(posedge clk);
    #2;
    req_valid = v; req_we = we; req_bank = b; req_addr = a;
    req_be = be; req_wdata = d; clr_req = clr;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 3'd0, 5'd0, 4'h0, 32'h0, 1'b0);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (busy != 0 && n < 3 * DEPTH) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("wait_ready", {31'b0, (busy == 0)}, 32'd1);
  endtask

  initial begin
    idle(3);
    #0 rst_n = 1'b1;
    // reset release with a read held pending through INIT
    req_valid = 1'b1; req_we = 1'b0; req_bank = 3'd3; req_addr = 5'd5;
    wait_ready();
    idle(1);
    // byte write then read, neighbouring bank untouched
    drive(1'b1, 1'b1, 3'd2, 5'h10, 4'h1, 32'h000000A5, 1'b0);
    drive(1'b1, 1'b0, 3'd2, 5'h10, 4'h0, 32'h0, 1'b0);
    drive(1'b1, 1'b0, 3'd1, 5'h10, 4'h0, 32'h0, 1'b0);
    // partial byte-enable merge, read in the next cycle
    drive(1'b1, 1'b1, 3'd4, 5'd7, 4'hF, 32'h11223344, 1'b0);
    drive(1'b1, 1'b1, 3'd4, 5'd7, 4'h5, 32'hAABBCCDD, 1'b0);
    drive(1'b1, 1'b0, 3'd4, 5'd7, 4'h0, 32'h0, 1'b0);
    drive(1'b1, 1'b1, 3'd6, 5'd9, 4'h0, 32'hFFFFFFFF, 1'b0);
    drive(1'b1, 1'b0, 3'd6, 5'd9, 4'h0, 32'h0, 1'b0);
    // back-to-back reads across all banks
    for (int b = 0; b < BANKS; b++) drive(1'b1, 1'b0, 3'(b), 5'h10, 4'h0, 32'h0, 1'b0);
    idle(3);
    // read coinciding with a clear, then re-read of a written row
    drive(1'b1, 1'b1, 3'd0, 5'd1, 4'hF, 32'hDEADBEEF, 1'b0);
    drive(1'b1, 1'b0, 3'd0, 5'd1, 4'h0, 32'h0, 1'b1);
    idle(1);
    wait_ready();
    drive(1'b1, 1'b0, 3'd0, 5'd1, 4'h0, 32'h0, 1'b0);
    idle(3);
    // reset while a read is in flight
    drive(1'b1, 1'b0, 3'd5, 5'd0, 4'h0, 32'h0, 1'b0);
    @(posedge clk);
    #2;
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    wait_ready();
    // randomized traffic on a small address window to force read-after-write hits
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(3, 0) != 0), $urandom_range(1, 0), 3'($urandom_range(7, 0)),
            5'($urandom_range(3, 0)), 4'($urandom_range(15, 0)), $urandom,
            ($urandom_range(49, 0) == 0));
    end
    idle(1);
    wait_ready();
    idle(6);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
